vv_add_seq: RTL and testbench

Sequencer for the vector-vector add engine. On a start pulse it walks an element index from 0 to len-1 and issues one read per element to the A and B operand memories. It adds the returned pair and writes the sum to the C result memory at the same index. It sits between the host command interface and the three element memories, and reports busy, done and a sticky overflow flag back to the host.

---
 rtl/vv_add_seq.sv | 99 +++++++++
 tb/tb_vv_add_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vv_add_seq.sv
// Vector-vector add sequencer: walks 0..len-1 issuing A/B reads, writes A+B to C
// one cycle later, and reports busy/done plus a sticky carry-out flag.
module vv_add_seq #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic              stall,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] a_rdata,
  input  logic [DATA_W-1:0] b_rdata,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   idx, idx_nxt, last_idx;
  logic [ADDR_W-1:0] len_r;
  logic              wr_en_p1;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [DATA_W:0]   sum_p1;

  // Sum with the carry kept in the extra top bit.
  function automatic logic [DATA_W:0] add_carry(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // len_r == 0 stands for a full 2^ADDR_W run, so the count needs one more bit.
  assign last_idx = {(len_r == '0), len_r} - (ADDR_W+1)'(1);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    rd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          idx_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        rd_en = !stall;
        if (!stall) begin
          idx_nxt = idx + (ADDR_W+1)'(1);
          if (idx == last_idx) state_nxt = DRAIN;
        end
      end
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_addr = idx[ADDR_W-1:0];
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      len_r      <= '0;
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      ovf        <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      // Stage p0 -> p1: read issue becomes a write one cycle later.
      wr_en_p1   <= rd_en;
      wr_addr_p1 <= rd_addr;
      if (state == IDLE && start) begin
        len_r <= len;
        ovf   <= 1'b0;
      end else if (wr_en_p1 && sum_p1[DATA_W]) begin
        ovf <= 1'b1;
      end
    end
  end

  // Stage p1: operands arrive from memory and are summed combinationally.
  assign sum_p1  = add_carry(a_rdata, b_rdata);
  assign wr_en   = wr_en_p1;
  assign wr_addr = wr_addr_p1;
  assign wr_data = wr_en_p1 ? sum_p1[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_vv_add_seq.sv
// Bench for vv_add_seq: A/B/C memory models, cycle-level command model, and a
// write scoreboard drained by an independent monitor.
`timescale 1ns/1ps
module tb_vv_add_seq;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              stall = 1'b0;
  logic [ADDR_W-1:0] len = '0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy, done, ovf;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [DATA_W-1:0] mem_c [DEPTH];

  typedef struct {
    int                cyc;
    int                addr;
    logic [DATA_W-1:0] data;
  } wr_t;
  wr_t sb[$];

  int gcyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vv_add_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .stall(stall),
    .rd_en(rd_en), .rd_addr(rd_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .ovf(ovf)
  );

  // Synchronous memories: read data valid the cycle after rd_en.
  always @(posedge clk) begin
    gcyc <= gcyc + 1;
    if (rd_en === 1'b1) begin
      a_rdata <= mem_a[rd_addr];
      b_rdata <= mem_b[rd_addr];
    end
    if (wr_en === 1'b1) mem_c[wr_addr] <= wr_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, gcyc);
    end
  endtask

  // Monitor: every write the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin : monitor
    wr_t e;
    while (sb.size() > 0 && sb[0].cyc < gcyc) begin
      e = sb.pop_front();
      check("wr_missing_cycle", 64'(gcyc), 64'(e.cyc));
    end
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("wr_unexpected", 64'(wr_en), 64'(0));
      end else begin
        e = sb.pop_front();
        check("wr_cycle", 64'(gcyc), 64'(e.cyc));
        check("wr_addr", 64'(wr_addr), 64'(e.addr));
        check("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  // One command from start to first IDLE cycle. stall_pct < 0 uses mask[c] for cycles 0..7.
  task automatic run_cmd(input int n, input int stall_pct, input logic [7:0] mask, input bit inj);
    int nel = (n == 0) ? DEPTH : n;
    int reads = 0;
    int last_c = -1;
    bit exp_ovf = 1'b0;
    bit exp_rd;
    logic [DATA_W:0] s;
    @(negedge clk);
    start = 1'b1;
    len   = ADDR_W'(n);
    stall = 1'b0;
    @(posedge clk); #1;
    for (int c = 1; c < 4000; c++) begin
      if (stall_pct < 0)            stall = (c < 8) ? mask[c] : 1'b0;
      else if (reads < nel && c < 300) stall = ($urandom_range(99) < stall_pct);
      else if (reads < nel)         stall = 1'b0;
      else                          stall = 1'($urandom_range(1));
      start = inj && (c == 2);
      if (start) len = ADDR_W'($urandom);
      exp_rd = (reads < nel) && !stall;
      if (exp_rd) begin
        s = {1'b0, mem_a[reads]} + {1'b0, mem_b[reads]};
        if (s[DATA_W]) exp_ovf = 1'b1;
        sb.push_back('{gcyc + 1, reads, s[DATA_W-1:0]});
        reads++;
        if (reads == nel) last_c = c;
      end
      @(negedge clk);
      check("rd_en", 64'(rd_en), 64'(exp_rd));
      if (exp_rd) check("rd_addr", 64'(rd_addr), 64'(reads - 1));
      check("busy", 64'(busy), 64'((last_c < 0) || (c <= last_c + 2)));
      check("done", 64'(done), 64'((last_c >= 0) && (c == last_c + 2)));
      if (c == 1) check("ovf_cleared", 64'(ovf), 64'(0));
      if (last_c >= 0 && c >= last_c + 2) check("ovf_final", 64'(ovf), 64'(exp_ovf));
      if (last_c >= 0 && c == last_c + 3) break;
      if (c >= 3999) check("run_timeout", 64'(c), 64'(0));
      @(posedge clk); #1;
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
      mem_c[i] = '0;
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", 64'(rd_en), 64'(0));
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_wr_addr", 64'(wr_addr), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    rst = 1'b1;

    // Basic run
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = DATA_W'(i + 1);
      mem_b[i] = DATA_W'(10 * (i + 1));
    end
    run_cmd(4, 0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) check("basic_c", 64'(mem_c[i]), 64'(11 * (i + 1)));

    // Full depth, no stall
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end
    run_cmd(0, 0, 8'h00, 1'b0);

    // Stall in cycles 2 and 3
    run_cmd(3, -1, 8'b0000_1100, 1'b0);

    // Overflow, then held through IDLE, then cleared by the next start
    mem_a[0] = '1;
    mem_b[0] = DATA_W'(1);
    run_cmd(1, 0, 8'h00, 1'b0);
    check("ovf_c0", 64'(mem_c[0]), 64'(0));
    repeat (5) @(negedge clk);
    check("ovf_idle_hold", 64'(ovf), 64'(1));
    mem_a[0] = DATA_W'(5);
    mem_b[0] = DATA_W'(6);
    run_cmd(5, 0, 8'h00, 1'b0);

    // Start pulsed during RUN is ignored
    run_cmd(6, 20, 8'h00, 1'b1);

    // Randomized commands with random stalls
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i] = $urandom;
        mem_b[i] = $urandom;
      end
      run_cmd(int'($urandom_range(DEPTH - 1)), 30, 8'h00, 1'($urandom_range(1)));
    end

    // Reset in cycle 3 of a len=8 run
    @(negedge clk);
    start = 1'b1;
    len   = ADDR_W'(8);
    stall = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      sb.push_back('{gcyc + 1, c - 1, DATA_W'(mem_a[c-1] + mem_b[c-1])});
      if (c == 3) rst = 1'b0;
      @(negedge clk);
      check("abort_rd_en", 64'(rd_en), 64'(1));
      check("abort_rd_addr", 64'(rd_addr), 64'(c - 1));
      @(posedge clk); #1;
    end
    sb.delete();
    rst = 1'b1;
    @(negedge clk);
    check("abort_rd_en_off", 64'(rd_en), 64'(0));
    check("abort_wr_en", 64'(wr_en), 64'(0));
    check("abort_wr_addr", 64'(wr_addr), 64'(0));
    check("abort_wr_data", 64'(wr_data), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_ovf", 64'(ovf), 64'(0));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'(0));
      check("abort_idle", 64'(busy), 64'(0));
    end

    // Fresh command after the abort
    run_cmd(5, 0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
